// File: rtl/sar_sched_pkg.sv
// Shared types, default timing and sizing helpers for the SAR conversion scheduler.
package sar_sched_pkg;

  // Scheduler FSM encoding, kept as plain constants for legacy tool flows.
  typedef logic [2:0] sched_state_e;

  localparam sched_state_e S_IDLE    = 3'd0;
  localparam sched_state_e S_ARB     = 3'd1;
  localparam sched_state_e S_SETTLE  = 3'd2;
  localparam sched_state_e S_SAMPLE  = 3'd3;
  localparam sched_state_e S_CONVERT = 3'd4;
  localparam sched_state_e S_OUTPUT  = 3'd5;

  localparam int DEF_N           = 10;
  localparam int DEF_NCH         = 4;
  localparam int DEF_SETTLE_CYC  = 4;
  localparam int DEF_SAMPLE_CYC  = 2;
  localparam int DEF_TIMEOUT_CYC = 64;

  // Width of the shared phase counter: must hold the largest terminal count.
  function automatic int cnt_width(input int settle_cyc, input int sample_cyc,
                                   input int timeout_cyc);
    int m;
    m = settle_cyc;
    if (sample_cyc > m) m = sample_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sar_conv_sched_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pend_i at or after rr_ptr_i, wrapping.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] pend_i,
  input  logic [CHW-1:0] rr_ptr_i,
  output logic [CHW-1:0] grant_idx_o,
  output logic           grant_vld_o
);

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (pend_i[idx[CHW-1:0]]) begin
        grant_idx_o = CHW'(idx);
        grant_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_conv_sched.sv
// Multi-channel SAR conversion scheduler: collects requests, grants round-robin,
// sequences mux settle / sample / convert and presents tagged results on a stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | nothing in flight, waiting for a pending request
//   ARB     | one cycle: pick channel, latch mux_sel, advance rr_ptr
//   SETTLE  | SETTLE_CYC cycles for the analog mux to settle
//   SAMPLE  | SAMPLE_CYC cycles with sample_en high
//   CONVERT | conv_start on first cycle, wait for conv_done or timeout
//   OUTPUT  | hold result until res_ready, then ARB or IDLE
module sar_conv_sched
  import sar_sched_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int NCH         = DEF_NCH,
  parameter int CHW         = $clog2(NCH),
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int SAMPLE_CYC  = DEF_SAMPLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ch_req,
  input  logic [NCH-1:0] ch_en,
  input  logic           ovr_clr,
  output logic [CHW-1:0] mux_sel,
  output logic           sample_en,
  output logic           conv_start,
  input  logic           conv_done,
  input  logic [N-1:0]   conv_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_data,
  output logic [CHW-1:0] res_ch,
  output logic           busy,
  output logic [NCH-1:0] ovr_flag,
  output logic           timeout_err
);

  localparam int CW = cnt_width(SETTLE_CYC, SAMPLE_CYC, TIMEOUT_CYC);

  sched_state_e   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0] mux_sel_q, mux_sel_d;
  logic           res_valid_q, res_valid_d;
  logic [N-1:0]   res_data_q, res_data_d;
  logic [CHW-1:0] res_ch_q, res_ch_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic           tout_q, tout_d;
  logic           tout_set;

  logic [CHW-1:0] grant_idx;
  logic           grant_vld;
  logic           grant_take;
  logic [NCH-1:0] gnt_vec;
  logic [NCH-1:0] req_v;
  logic [NCH-1:0] ovr_set;

  // A channel dropped from ch_en in the same cycle must not be granted.
  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .pend_i      (pending_q & ch_en),
    .rr_ptr_i    (rr_ptr_q),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign grant_take = (state_q == S_ARB) && grant_vld;
  assign req_v      = ch_req & ch_en;

  // One-hot of the channel being granted this cycle.
  always_comb begin
    gnt_vec = '0;
    if (grant_take) gnt_vec[grant_idx] = 1'b1;
  end

  // A request landing on the grant cycle re-arms pending without counting as overrun.
  always_comb begin
    pending_d = ch_en & (req_v | (pending_q & ~gnt_vec));
    ovr_set   = req_v & pending_q & ~gnt_vec;
    ovr_d     = (ovr_q & ~{NCH{ovr_clr}}) | ovr_set;
    tout_d    = (tout_q & ~ovr_clr) | tout_set;
  end

  // Sequencing of grant, settle, sample, convert and result hand-off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    mux_sel_d   = mux_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    tout_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) state_d = S_ARB;
      end
      S_ARB: begin
        if (grant_vld) begin
          mux_sel_d = grant_idx;
          rr_ptr_d  = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);
          cnt_d     = '0;
          state_d   = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CONVERT: begin
        if (conv_done) begin
          res_data_d  = conv_data;
          res_ch_d    = mux_sel_q;
          res_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tout_set = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = (|pending_q) ? S_ARB : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any conversion and drops pending work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      mux_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      ovr_q       <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      mux_sel_q   <= mux_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      ovr_q       <= ovr_d;
      tout_q      <= tout_d;
    end
  end

  assign mux_sel     = mux_sel_q;
  assign sample_en   = (state_q == S_SAMPLE);
  assign conv_start  = (state_q == S_CONVERT) && (cnt_q == '0);
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_ch      = res_ch_q;
  assign busy        = (state_q != S_IDLE);
  assign ovr_flag    = ovr_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_sar_conv_sched.sv
// Bench for sar_conv_sched with a behavioural SAR core and a round-robin order model.
module tb_sar_conv_sched;

  localparam int N   = 10;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] ch_req = '0;
  logic [NCH-1:0] ch_en = '1;
  logic           ovr_clr = 1'b0;
  logic           res_ready = 1'b1;
  logic           conv_done;
  logic [N-1:0]   conv_data;
  logic [CHW-1:0] mux_sel;
  logic           sample_en;
  logic           conv_start;
  logic           res_valid;
  logic [N-1:0]   res_data;
  logic [CHW-1:0] res_ch;
  logic           busy;
  logic [NCH-1:0] ovr_flag;
  logic           timeout_err;

  int errors = 0;
  int checks = 0;
  int rr_m   = 0;

  logic         sar_en        = 1'b1;
  int           sar_dly       = 10;
  logic         sar_fixed     = 1'b0;
  logic [N-1:0] sar_fixed_val = '0;
  logic         late_done     = 1'b0;

  int           got_ch[$];
  logic [N-1:0] got_data[$];
  logic [N-1:0] sent_q[$];

  sar_conv_sched dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_en(ch_en), .ovr_clr(ovr_clr),
    .mux_sel(mux_sel), .sample_en(sample_en), .conv_start(conv_start),
    .conv_done(conv_done), .conv_data(conv_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch), .busy(busy),
    .ovr_flag(ovr_flag), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // SAR core model: answers conv_start with conv_done sar_dly cycles later.
  initial begin : sar_model
    int cnt;
    logic [N-1:0] d;
    cnt = 0;
    d = '0;
    conv_done = 1'b0;
    conv_data = '0;
    forever begin
      @(negedge clk);
      conv_done = 1'b0;
      if (rst) cnt = 0;
      else if (late_done) begin
        conv_done = 1'b1;
        conv_data = 10'h155;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          conv_done = 1'b1;
          conv_data = d;
        end
      end else if (sar_en && conv_start) begin
        d = sar_fixed ? sar_fixed_val : N'($urandom);
        sent_q.push_back(d);
        cnt = sar_dly;
      end
    end
  end

  // Result stream monitor.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        got_ch.push_back(int'(res_ch));
        got_data.push_back(res_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int quiet, n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < budget) begin
      step();
      n++;
      if (busy) quiet = 0; else quiet++;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  // Issue a burst of requests at once and compare results with round-robin order.
  task automatic run_batch(input logic [NCH-1:0] mask, input string name);
    int exp[$];
    int base_g, base_s, last;
    base_g = got_ch.size();
    base_s = sent_q.size();
    last = rr_m;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (rr_m + k) % NCH;
      if (mask[c]) begin
        exp.push_back(c);
        last = c;
      end
    end
    rr_m = (last + 1) % NCH;
    ch_req = mask;
    step();
    ch_req = '0;
    wait_quiet(400, name);
    checks++;
    if (got_ch.size() - base_g != exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d results, required %0d", name, got_ch.size() - base_g, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (base_g + i < got_ch.size() && base_s + i < sent_q.size()) begin
        checks++;
        if (got_ch[base_g + i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_ch[%0d]: got %0d, required %0d", name, i, got_ch[base_g + i], exp[i]);
        end
        checks++;
        if (got_data[base_g + i] !== sent_q[base_s + i]) begin
          errors++;
          $display("FAIL %s_data[%0d]: got %h, required %h", name, i, got_data[base_g + i], sent_q[base_s + i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({mux_sel, sample_en, conv_start, res_valid, res_data, res_ch, busy, ovr_flag, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b res_valid=%0b ovr=%b, required all 0", busy, res_valid, ovr_flag);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({busy, res_valid, sample_en, conv_start, ovr_flag, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_release: busy=%0b res_valid=%0b, required 0", busy, res_valid);
    end
    rr_m = 0;
  endtask

  task automatic test_round_robin();
    sar_fixed = 1'b0;
    sar_dly = $urandom_range(1, 20);
    run_batch(4'b1111, "rr_all");
    sar_dly = $urandom_range(1, 20);
    run_batch(4'b0011, "rr_01");
    run_batch(4'b0001, "rr_ptr1");
    sar_dly = $urandom_range(1, 20);
    run_batch(4'b1001, "rr_wrap");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      sar_dly = $urandom_range(1, 20);
      run_batch(NCH'($urandom_range(1, 15)), "rand");
    end
  endtask

  task automatic test_single();
    int t_arb, t_cs, t_rv, n_se, n_rv;
    logic [CHW-1:0] mux_at, rch;
    logic [N-1:0] rdat;
    t_arb = -1; t_cs = -1; t_rv = -1; n_se = 0; n_rv = 0;
    mux_at = '0; rch = '0; rdat = '0;
    sar_fixed = 1'b1;
    sar_fixed_val = 10'h2A5;
    sar_dly = 10;
    ch_req = 4'b0100;
    step();
    ch_req = '0;
    for (int t = 0; t < 50; t++) begin
      if (busy && t_arb < 0) t_arb = t;
      if (t_arb >= 0 && t == t_arb + 1) mux_at = mux_sel;
      if (sample_en) n_se++;
      if (conv_start && t_cs < 0) t_cs = t;
      if (res_valid) begin
        n_rv++;
        if (t_rv < 0) begin
          t_rv = t;
          rch = res_ch;
          rdat = res_data;
        end
      end
      step();
    end
    sar_fixed = 1'b0;
    rr_m = 3;
    checks++;
    if (mux_at !== 2'd2) begin errors++; $display("FAIL single_mux_sel: got %0d, required 2", mux_at); end
    checks++;
    if (n_se != 2) begin errors++; $display("FAIL single_sample_len: got %0d, required 2", n_se); end
    checks++;
    if (t_arb < 0 || t_cs - t_arb != 7) begin
      errors++;
      $display("FAIL single_start_latency: got %0d, required 7", t_cs - t_arb);
    end
    checks++;
    if (t_cs < 0 || t_rv - t_cs != 11) begin
      errors++;
      $display("FAIL single_valid_latency: got %0d, required 11", t_rv - t_cs);
    end
    checks++;
    if (n_rv != 1) begin errors++; $display("FAIL single_valid_len: got %0d, required 1", n_rv); end
    checks++;
    if (rch !== 2'd2 || rdat !== 10'h2A5) begin
      errors++;
      $display("FAIL single_result: got ch=%0d data=%h, required ch=2 data=2a5", rch, rdat);
    end
  endtask

  task automatic test_backpressure();
    int base_g, n, bad;
    logic [CHW-1:0] hold_ch;
    logic [N-1:0] hold_dat;
    base_g = got_ch.size();
    sar_dly = 5;
    res_ready = 1'b0;
    ch_req = 4'b0001;
    step();
    ch_req = '0;
    n = 0;
    while (!res_valid && n < 60) begin step(); n++; end
    checks++;
    if (!res_valid) begin errors++; $display("FAIL bp_valid: res_valid=0 after 60 cycles, required 1"); end
    hold_ch = res_ch;
    hold_dat = res_data;
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      ch_req = (t == 5 || t == 12) ? 4'b0010 : 4'b0000;
      step();
      if (!res_valid || res_ch !== hold_ch || res_data !== hold_dat) bad++;
    end
    ch_req = '0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, required 0", bad); end
    checks++;
    if (hold_ch !== 2'd0) begin errors++; $display("FAIL bp_ch: got %0d, required 0", hold_ch); end
    checks++;
    if (ovr_flag !== 4'b0010) begin errors++; $display("FAIL bp_ovr: got %b, required 0010", ovr_flag); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %0b, required 1", busy); end
    res_ready = 1'b1;
    wait_quiet(100, "bp");
    checks++;
    if (got_ch.size() - base_g != 2) begin
      errors++;
      $display("FAIL bp_count: got %0d results, required 2", got_ch.size() - base_g);
    end else begin
      checks++;
      if (got_ch[base_g] !== 0 || got_ch[base_g + 1] !== 1) begin
        errors++;
        $display("FAIL bp_order: got %0d,%0d, required 0,1", got_ch[base_g], got_ch[base_g + 1]);
      end
    end
    checks++;
    if (ovr_flag !== 4'b0010) begin errors++; $display("FAIL bp_ovr_sticky: got %b, required 0010", ovr_flag); end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checks++;
    if (ovr_flag !== 4'b0000) begin errors++; $display("FAIL bp_ovr_clr: got %b, required 0000", ovr_flag); end
    rr_m = 2;
  endtask

  task automatic test_timeout();
    int base_g, t, t_cs, t_to, nrv;
    logic busy_at;
    base_g = got_ch.size();
    t = 0; t_cs = -1; t_to = -1; nrv = 0; busy_at = 1'b1;
    sar_en = 1'b0;
    sar_dly = 4;
    ch_req = 4'b1000;
    step();
    ch_req = '0;
    while (t_to < 0 && t < 150) begin
      if (conv_start && t_cs < 0) t_cs = t;
      ch_req = (t_cs >= 0 && t == t_cs + 10) ? 4'b0010 : 4'b0000;
      if (res_valid) nrv++;
      if (timeout_err) begin
        t_to = t;
        busy_at = busy;
        sar_en = 1'b1;
      end else begin
        step();
        t++;
      end
    end
    ch_req = '0;
    sar_en = 1'b1;
    checks++;
    if (t_to < 0 || t_cs < 0 || t_to - t_cs != 64) begin
      errors++;
      $display("FAIL timeout_latency: got %0d, required 64", t_to - t_cs);
    end
    checks++;
    if (nrv != 0) begin errors++; $display("FAIL timeout_no_result: got %0d valid cycles, required 0", nrv); end
    checks++;
    if (busy_at !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%0b, required 0", busy_at); end
    wait_quiet(100, "timeout");
    checks++;
    if (got_ch.size() - base_g != 1 || got_ch[got_ch.size() - 1] !== 1) begin
      errors++;
      $display("FAIL timeout_next: got %0d results, required 1 from ch1", got_ch.size() - base_g);
    end
    checks++;
    if (timeout_err !== 1'b1 || ovr_flag !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_sticky: got terr=%0b ovr=%b, required 1 0000", timeout_err, ovr_flag);
    end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clr: got %0b, required 0", timeout_err); end
    rr_m = 2;
  endtask

  task automatic test_enable_mask();
    int base_g, nb, n;
    base_g = got_ch.size();
    sar_dly = 3;
    ch_en = 4'b1011;
    ch_req = 4'b0100;
    step();
    ch_req = '0;
    nb = 0;
    for (int t = 0; t < 15; t++) begin
      if (busy) nb++;
      step();
    end
    checks++;
    if (nb != 0 || got_ch.size() != base_g) begin
      errors++;
      $display("FAIL en_masked_req: busy cycles %0d, results %0d, required 0 0", nb, got_ch.size() - base_g);
    end
    res_ready = 1'b0;
    ch_req = 4'b0001;
    step();
    ch_req = '0;
    n = 0;
    while (!res_valid && n < 60) begin step(); n++; end
    ch_req = 4'b1000;
    step();
    ch_req = '0;
    ch_en = 4'b0011;
    step();
    res_ready = 1'b1;
    wait_quiet(40, "en_drop");
    checks++;
    if (got_ch.size() - base_g != 1 || got_ch[got_ch.size() - 1] !== 0) begin
      errors++;
      $display("FAIL en_drop_count: got %0d results, required 1 from ch0", got_ch.size() - base_g);
    end
    checks++;
    if (ovr_flag !== 4'b0000) begin errors++; $display("FAIL en_drop_ovr: got %b, required 0000", ovr_flag); end
    ch_en = 4'b1111;
    rr_m = 1;
  endtask

  task automatic test_reset_mid();
    int n, nrv, nb;
    sar_en = 1'b0;
    ch_req = 4'b0100;
    step();
    ch_req = '0;
    n = 0;
    while (!conv_start && n < 30) begin step(); n++; end
    step();
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %0b, required 1", busy); end
    rst = 1'b1;
    #2;
    checks++;
    if ({mux_sel, sample_en, conv_start, res_valid, res_data, res_ch, busy, ovr_flag, timeout_err} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: busy=%0b mux_sel=%0d, required all 0", busy, mux_sel);
    end
    step();
    step();
    rst = 1'b0;
    rr_m = 0;
    step();
    late_done = 1'b1;
    step();
    late_done = 1'b0;
    nrv = 0;
    nb = 0;
    for (int t = 0; t < 10; t++) begin
      if (res_valid) nrv++;
      if (busy) nb++;
      step();
    end
    checks++;
    if (nrv != 0 || nb != 0) begin
      errors++;
      $display("FAIL rstmid_late_done: valid %0d busy %0d cycles, required 0 0", nrv, nb);
    end
    sar_en = 1'b1;
    sar_dly = $urandom_range(1, 20);
    run_batch(4'b0110, "rstmid_after");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_random();
    test_single();
    test_backpressure();
    test_timeout();
    test_enable_mask();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_conv_sched.md
Name: sar_conv_sched

Overview:
- Multi-channel conversion scheduler for the RNM SAR ADC core.
- Collects per-channel conversion requests and grants them round-robin.
- For each grant: drives the analog input mux select, times settle and sample windows, starts the SAR core, waits for its done strobe, and presents the tagged result on a valid/ready stream.
- Sits between the digital sensor-control logic and the SAR ADC core plus its input mux.

Parameters:
- N, 10, SAR resolution in bits; width of conv_data and res_data.
- NCH, 4, number of input channels, 2..16.
- CHW, $clog2(NCH), channel index width.
- SETTLE_CYC, 4, mux settle cycles after mux_sel changes, >=1.
- SAMPLE_CYC, 2, cycles sample_en is held high, >=1.
- TIMEOUT_CYC, 64, maximum cycles from conv_start to conv_done.

Ports:
- clk  input  1  scheduler clock; also the SAR clock domain.
- rst  input  1  asynchronous, active-high reset.
- ch_req  input  NCH  one-cycle request pulse per channel.
- ch_en  input  NCH  channel enable mask; a disabled channel's requests are dropped.
- ovr_clr  input  1  pulse; clears ovr_flag and timeout_err.
- mux_sel  output  CHW  analog mux select.
- sample_en  output  1  track/hold sample window.
- conv_start  output  1  one-cycle start pulse to the SAR core.
- conv_done  input  1  one-cycle done strobe from the SAR core.
- conv_data  input  N  SAR code; valid when conv_done=1.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accept.
- res_data  output  N  latched conversion code.
- res_ch  output  CHW  channel tag of res_data.
- busy  output  1  high in any state other than IDLE.
- ovr_flag  output  NCH  sticky per-channel request-overrun flag.
- timeout_err  output  1  sticky conversion-timeout flag.

Behaviour:
- Reset (async assert, sync release): all outputs 0, pending=0, rr_ptr=0, state=IDLE.
- Pending register:
  - ch_req[i] & ch_en[i] sets pending[i].
  - If pending[i] is already 1 (and is not being granted this cycle), ovr_flag[i] is set. The request merges and is not queued twice.
  - Clearing ch_en[i] clears pending[i] immediately; an in-flight conversion for i still completes.
  - A request arriving in the same cycle as the grant of that channel leaves pending[i]=1 (the new request) and does not set ovr_flag.
- FSM states: IDLE, ARB, SETTLE, SAMPLE, CONVERT, OUTPUT.
- IDLE -> ARB when any pending bit is set.
- ARB (1 cycle):
  - Picks the first pending channel at or after rr_ptr, with wrap-around.
  - Clears its pending bit, latches mux_sel, and sets rr_ptr = grant+1 mod NCH.
  - Goes to SETTLE.
- SETTLE: counts SETTLE_CYC cycles, then SAMPLE. mux_sel holds from ARB until the next ARB.
- SAMPLE: sample_en=1 for exactly SAMPLE_CYC cycles.
- SAMPLE -> CONVERT: conv_start=1 on the first CONVERT cycle only. The timeout counter starts at 0 in that cycle.
- CONVERT:
  - conv_done=1 latches conv_data into res_data and mux_sel into res_ch, asserts res_valid, and goes to OUTPUT.
  - If the counter reaches TIMEOUT_CYC-1 without conv_done: sets timeout_err, emits no result, returns to IDLE.
  - conv_done outside CONVERT is ignored.
- OUTPUT:
  - Holds res_valid/res_data/res_ch stable until res_valid & res_ready.
  - The transfer cycle returns to IDLE if nothing is pending, otherwise goes directly to ARB.
  - Backpressure stalls scheduling; requests keep accumulating in pending.
- Latency:
  - Grant to conv_start = 1 + SETTLE_CYC + SAMPLE_CYC cycles.
  - With an always-ready sink: res_valid rises the cycle after conv_done.
- ovr_clr clears ovr_flag and timeout_err. A set event in the same cycle wins over clear.
- rst mid-conversion aborts immediately: no result, pending lost, outputs to 0.
- Widths:
  - Counters are sized $clog2(max(SETTLE_CYC, SAMPLE_CYC, TIMEOUT_CYC)+1).
  - rr_ptr wraps modulo NCH, including non-power-of-two NCH.

Decomposition:
- Package sar_sched_pkg holds:
  - the state enum typedef sched_state_e;
  - the default timing localparams;
  - a function computing the counter width.
- Sub-module rr_arbiter #(NCH): combinational round-robin pick from a pending vector and rr_ptr. It outputs grant_idx and grant_vld. The main FSM instantiates it in ARB.

Test Plan:
- Single channel: NCH=4, ch_req=4'b0100, conv_done 10 cycles after conv_start with conv_data=10'h2A5, res_ready=1.
  - Required: mux_sel=2, sample_en high for 2 cycles.
  - Required: conv_start 7 cycles after ARB, then res_ch=2 and res_data=10'h2A5 for 1 cycle.
- Round-robin: ch_req=4'b1111 in one cycle.
  - Required: conversions in order 0,1,2,3.
  - Then ch_req=4'b0011 with rr_ptr=0 gives 0,1. With rr_ptr=1, a request 4'b1001 gives 3 then 0.
- Backpressure plus overrun: hold res_ready=0 for 30 cycles after result ch0, and pulse ch_req[1] twice.
  - Required: res_data stable, ovr_flag=4'b0010, and exactly one ch1 conversion after release.
  - ovr_clr then gives ovr_flag=0.
- Timeout: never drive conv_done.
  - Required: timeout_err=1 exactly 64 cycles after conv_start, no res_valid, FSM back in IDLE.
  - The next pending request is serviced normally.
- Enable mask: ch_en=4'b1011 with ch_req=4'b0100 gives no conversion. Pending ch3 with ch_en[3] cleared gives pending dropped and busy=0.
- Reset during CONVERT: assert rst mid-conversion.
  - Required: all outputs 0 asynchronously.
  - A late conv_done after release is ignored, with no res_valid.
